trace_event_monitor: RTL and testbench

- Synthesisable, N-core generalisation of the per-core r3-shadow, trace-monitor and termination logic used in simulation benches.
- Consumes mor1kx execution-trace beats from NUM_CORES cores and decodes the simulation l.nop conventions: EXIT, REPORT and PUTC.
- Per-core event FIFOs are merged round-robin into one valid/ready event stream, so bench or host logic can collect console output and exit codes without DPI/$fwrite.
- Tracks per-core and global termination.

---
 rtl/trace_mon_pkg.sv | 20 ++
 rtl/trace_event_fifo.sv | 46 ++++
 rtl/trace_event_monitor.sv | 156 +++++++++++++++
 tb/tb_trace_event_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_mon_pkg.sv
// Shared types and l.nop decode constants for the trace event monitor.
package trace_mon_pkg;

  typedef enum logic [1:0] {
    EVT_EXIT   = 2'd0,
    EVT_REPORT = 2'd1,
    EVT_PUTC   = 2'd2
  } evt_type_t;

  localparam logic [7:0]  NOP_OPCODE = 8'h15;
  localparam logic [15:0] NOP_EXIT   = 16'h1;
  localparam logic [15:0] NOP_REPORT = 16'h2;
  localparam logic [15:0] NOP_PUTC   = 16'h4;

  typedef struct packed {
    evt_type_t   evt_type;
    logic [31:0] data;
  } trace_evt_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Single-clock FIFO of trace events; wrap-bit pointers give full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_event_fifo
  import trace_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trace_evt_t push_data,
  input  logic       pop,
  output trace_evt_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  trace_evt_t   mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_event_monitor.sv
// Decodes l.nop EXIT/REPORT/PUTC from N mor1kx trace ports into one event stream.
// Optional idle watchdog: define TRACE_EVENT_MONITOR_WATCHDOG_EN.
module trace_event_monitor
  import trace_mon_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      trace_valid,
  input  logic [32*NUM_CORES-1:0]   trace_insn,
  input  logic [NUM_CORES-1:0]      trace_wben,
  input  logic [5*NUM_CORES-1:0]    trace_wbreg,
  input  logic [32*NUM_CORES-1:0]   trace_wbdata,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] evt_core,
  output logic [1:0]                evt_type,
  output logic [31:0]               evt_data,
  output logic [NUM_CORES-1:0]      core_done,
  output logic                      all_done,
  output logic [NUM_CORES-1:0]      ovf,
  output logic                      timeout
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop;
  logic [NUM_CORES-1:0] is_exit;
  logic [NUM_CORES-1:0] fifo_full;
  logic [NUM_CORES-1:0] fifo_empty;
  trace_evt_t           head_evt [NUM_CORES];

  logic                 grant_valid;
  logic [CW-1:0]        grant_idx;
  logic [CW-1:0]        arb_ptr;
  logic                 load;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [31:0] insn;
    logic [15:0] k;
    logic        is_nop;
    logic [31:0] r3_q;
    evt_type_t   ty;
    trace_evt_t  push_evt;
    trace_evt_t  pop_evt;
    logic [7:0]  unused_insn;

    assign insn        = trace_insn[32*g +: 32];
    assign k           = insn[15:0];
    assign unused_insn = insn[23:16];
    assign is_nop      = trace_valid[g] && (insn[31:24] == NOP_OPCODE);
    assign is_exit[g]  = is_nop && (k == NOP_EXIT);
    assign push[g]     = is_nop && ((k == NOP_EXIT) || (k == NOP_REPORT) || (k == NOP_PUTC));
    assign ty          = (k == NOP_EXIT) ? EVT_EXIT : (k == NOP_REPORT) ? EVT_REPORT : EVT_PUTC;
    // The nop beat itself never writes back, so the pre-beat shadow is the payload.
    assign push_evt    = '{evt_type: ty,
                           data: (k == NOP_PUTC) ? {24'h0, r3_q[7:0]} : r3_q};
    assign head_evt[g] = pop_evt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r3_q <= '0;
      end else if (trace_valid[g] && trace_wben[g] && (trace_wbreg[5*g +: 5] == 5'd3)) begin
        r3_q <= trace_wbdata[32*g +: 32];
      end
    end

    trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (push_evt),
      .pop       (pop[g]),
      .pop_data  (pop_evt),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Round-robin search beginning at the core after the last grant.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    pop         = '0;
    idx         = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(arb_ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_valid && !fifo_empty[CW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
    load = grant_valid && (!evt_valid || evt_ready);
    if (load) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_core  <= '0;
      evt_type  <= EVT_EXIT;
      evt_data  <= '0;
      arb_ptr   <= '0;
    end else if (!evt_valid || evt_ready) begin
      evt_valid <= grant_valid;
      if (grant_valid) begin
        evt_core <= grant_idx;
        evt_type <= head_evt[grant_idx].evt_type;
        evt_data <= head_evt[grant_idx].data;
        arb_ptr  <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_done <= '0;
      all_done  <= 1'b0;
      ovf       <= '0;
    end else begin
      core_done <= core_done | is_exit;
      all_done  <= &core_done;
      ovf       <= ovf | (push & fifo_full & ~pop);
    end
  end

`ifdef TRACE_EVENT_MONITOR_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (|trace_valid) begin
        wd_cnt <= '0;
      end else if (!all_done && (wd_cnt != TW'(TIMEOUT_CYCLES))) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_cnt == TW'(TIMEOUT_CYCLES)) timeout <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_trace_event_monitor.sv
// Directed bench for trace_event_monitor with hand-computed expected events.
module tb_trace_event_monitor;

  localparam int NC = 4;

  logic          clk;
  logic          rst;
  logic [NC-1:0] trace_valid;
  logic [32*NC-1:0] trace_insn;
  logic [NC-1:0] trace_wben;
  logic [5*NC-1:0] trace_wbreg;
  logic [32*NC-1:0] trace_wbdata;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_core;
  logic [1:0]    evt_type;
  logic [31:0]   evt_data;
  logic [NC-1:0] core_done;
  logic          all_done;
  logic [NC-1:0] ovf;
  logic          timeout;

  int n_cmp = 0;
  int n_err = 0;

  trace_event_monitor #(.NUM_CORES(NC), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_valid  (trace_valid),
    .trace_insn   (trace_insn),
    .trace_wben   (trace_wben),
    .trace_wbreg  (trace_wbreg),
    .trace_wbdata (trace_wbdata),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_core     (evt_core),
    .evt_type     (evt_type),
    .evt_data     (evt_data),
    .core_done    (core_done),
    .all_done     (all_done),
    .ovf          (ovf),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    trace_valid  = '0;
    trace_insn   = '0;
    trace_wben   = '0;
    trace_wbreg  = '0;
    trace_wbdata = '0;
  endtask

  task automatic idle(input int n);
    clear_beats();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clear_beats();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_wb(input int c, input logic [31:0] d);
    trace_valid[c]           = 1'b1;
    trace_insn[32*c +: 32]   = 32'he0630004;
    trace_wben[c]            = 1'b1;
    trace_wbreg[5*c +: 5]    = 5'd3;
    trace_wbdata[32*c +: 32] = d;
  endtask

  task automatic set_nop(input int c, input logic [15:0] k);
    trace_valid[c]           = 1'b1;
    trace_insn[32*c +: 32]   = {8'h15, 8'h00, k};
    trace_wben[c]            = 1'b0;
    trace_wbreg[5*c +: 5]    = 5'd0;
    trace_wbdata[32*c +: 32] = 32'h0;
  endtask

  initial begin
    evt_ready = 1'b1;
    do_reset();

    chk("rst_valid", evt_valid, 0);
    chk("rst_core", evt_core, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_done", {core_done, all_done}, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_timeout", timeout, 0);

    // REPORT from core 0, including a non-r3 write that must not touch the shadow
    clear_beats(); set_wb(0, 32'hDEADBEEF); tick();
    clear_beats(); set_wb(0, 32'h11111111); trace_wbreg[4:0] = 5'd4; tick();
    clear_beats(); set_nop(0, 16'h2); tick();
    clear_beats();
    chk("rep_not_yet", evt_valid, 0);
    tick();
    chk("rep_valid", evt_valid, 1);
    chk("rep_event", {evt_core, evt_type, evt_data}, {2'd0, 2'd1, 32'hDEADBEEF});
    tick();
    chk("rep_drained", evt_valid, 0);

    // PUTC from core 2; an unknown K on core 1 is ignored
    clear_beats(); set_wb(2, 32'h12345641); tick();
    clear_beats(); set_nop(2, 16'h4); set_nop(1, 16'h3); tick();
    clear_beats(); tick();
    chk("putc_event", {evt_valid, evt_core, evt_type, evt_data}, {1'b1, 2'd2, 2'd2, 32'h41});
    tick();
    chk("putc_only_one", evt_valid, 0);

    // Fairness: four simultaneous PUTCs, twice
    do_reset();
    clear_beats();
    for (int c = 0; c < NC; c++) set_wb(c, 32'h30 + c);
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      clear_beats();
      for (int c = 0; c < NC; c++) set_nop(c, 16'h4);
      tick();
      clear_beats();
      tick();
      for (int c = 0; c < NC; c++) begin
        chk("rr_event", {evt_valid, evt_core, evt_type, evt_data},
            {1'b1, 2'(c), 2'd2, 32'h30 + c});
        tick();
      end
      chk("rr_drained", evt_valid, 0);
    end

    // Backpressure and overflow on core 1
    do_reset();
    evt_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      clear_beats(); set_wb(1, 32'h100 + j); tick();
      clear_beats(); set_nop(1, 16'h2); tick();
      if (j == 4) chk("ovf_before", ovf, 0);
      if (j == 2) chk("bp_hold_mid", {evt_valid, evt_core, evt_data}, {1'b1, 2'd1, 32'h100});
    end
    clear_beats();
    chk("ovf_after", ovf, 4'b0010);
    tick(); tick();
    chk("bp_hold_end", {evt_valid, evt_core, evt_type, evt_data}, {1'b1, 2'd1, 2'd1, 32'h100});
    evt_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_release", {evt_valid, evt_core, evt_data}, {1'b1, 2'd1, 32'h100 + j});
      tick();
    end
    chk("bp_exactly5", evt_valid, 0);
    chk("ovf_sticky", ovf, 4'b0010);

    // Termination
    do_reset();
    clear_beats(); set_wb(3, 32'h7); tick();
    idle(8);
    for (int c = 0; c < NC; c++) begin
      clear_beats(); set_nop(c, 16'h1); tick();
      clear_beats();
      chk("done_bits", core_done, (4'b0001 << (c + 1)) - 4'b0001);
      chk("all_done_lag", all_done, 0);
      tick();
      chk("exit_event", {evt_valid, evt_core, evt_type, evt_data},
          {1'b1, 2'(c), 2'd0, (c == 3) ? 32'h7 : 32'h0});
      chk("all_done", all_done, (c == 3) ? 1 : 0);
      idle(8);
    end
    clear_beats(); set_nop(0, 16'h2); tick();
    clear_beats(); tick();
    chk("done_core_decodes", {evt_valid, evt_core, evt_type}, {1'b1, 2'd0, 2'd1});
    tick();

    // Watchdog
    do_reset();
`ifdef TRACE_EVENT_MONITOR_WATCHDOG_EN
    idle(99);
    clear_beats(); trace_valid[2] = 1'b1; tick();
    idle(60);
    chk("wd_restart", timeout, 0);
    idle(105);
    chk("wd_expire", timeout, 1);
    clear_beats(); trace_valid[0] = 1'b1; tick();
    idle(3);
    chk("wd_sticky", timeout, 1);
`else
    idle(120);
    chk("wd_off", timeout, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
